// File: rtl/uvc_iso_scheduler_pkg.sv
// Shared definitions for the isochronous IN scheduler: state encoding,
// packet ceilings and SI byte-counter width.
package uvc_iso_scheduler_pkg;

    localparam int unsigned MAX_PKTS_PER_SI = 48;
    localparam int unsigned ISO_PKT_BYTES   = 1024;
    localparam int unsigned SI_BYTES_W      = 16;
    localparam int unsigned PKT_CNT_W       = 6;
    localparam int unsigned OVR_CNT_W       = 8;

    typedef enum logic [2:0] {
        ST_DISABLED  = 3'd0,
        ST_WAIT_ITP  = 3'd1,
        ST_ACTIVE    = 3'd2,
        ST_EXHAUSTED = 3'd3,
        ST_DRAIN     = 3'd4
    } sched_state_e;

    // Budget request 0 means one packet; anything above the ceiling is clipped.
    function automatic logic [PKT_CNT_W-1:0] clamp_budget(
        input logic [PKT_CNT_W-1:0] req,
        input logic [PKT_CNT_W-1:0] max_pkts
    );
        logic [PKT_CNT_W-1:0] res;
        res = req;
        if (req == '0)
            res = PKT_CNT_W'(1);
        else if (req > max_pkts)
            res = max_pkts;
        return res;
    endfunction

endpackage

// File: rtl/uvc_sat_acc.sv
// Saturating accumulator with synchronous clear; also exposes the
// would-be next value so a caller can latch "acc + this add" in one cycle.
module uvc_sat_acc #(
    parameter int unsigned W     = 16,
    parameter int unsigned ADD_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_add_en,
    input  logic [ADD_W-1:0] i_add_val,
    output logic [W-1:0]     o_acc,
    output logic [W-1:0]     o_sum_c
);

    logic [W-1:0] r_acc;
    logic [W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + (W+1)'(i_add_val);

    always_comb begin
        o_sum_c = r_acc;
        if (i_add_en)
            o_sum_c = w_sum[W] ? '1 : w_sum[W-1:0];
    end

    // Clear wins over add: the added value is still visible on o_sum_c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else
            r_acc <= o_sum_c;
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/uvc_iso_scheduler.sv
// Isochronous IN scheduler: gates producer ready to a per-SI packet budget,
// counts bytes per SI and flags commits that fall outside the budget.
module uvc_iso_scheduler
    import uvc_iso_scheduler_pkg::*;
#(
    parameter int unsigned MAX_PKTS = MAX_PKTS_PER_SI,
    parameter int unsigned LEN_W    = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  intf_set,
    input  logic [PKT_CNT_W-1:0]  pkts_per_si,
    input  logic                  itp_recieved,
    input  logic                  ep_in_buf_ready,
    output logic                  sched_in_buf_ready,
    input  logic                  prod_wren,
    input  logic                  prod_commit,
    input  logic [LEN_W-1:0]      prod_commit_len,
    output logic                  sched_active,
    output logic [PKT_CNT_W-1:0]  pkts_left,
    output logic [SI_BYTES_W-1:0] si_bytes_sent,
    output logic                  si_bytes_valid,
    output logic [OVR_CNT_W-1:0]  overrun_cnt
);

    sched_state_e r_state, w_state_d;

    logic                  r_open, w_open_d;
    logic                  r_grant, w_grant_d;
    logic                  r_active;
    logic                  r_valid, w_valid_d;
    logic [PKT_CNT_W-1:0]  r_pkts_left, w_pkts_d, w_budget;
    logic [SI_BYTES_W-1:0] r_bytes_sent, w_bytes_d;
    logic [SI_BYTES_W-1:0] w_acc_q, w_acc_sum;
    logic                  w_acc_clr;
    logic                  w_legal, w_illegal;
    logic [OVR_CNT_W-1:0]  w_ovr_q, w_ovr_sum_unused;

    assign w_budget  = clamp_budget(pkts_per_si, PKT_CNT_W'(MAX_PKTS));
    assign w_legal   = prod_commit && r_open && (r_pkts_left != '0);
    assign w_illegal = prod_commit && !w_legal;

    uvc_sat_acc #(
        .W     (SI_BYTES_W),
        .ADD_W (LEN_W)
    ) u_byte_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_acc_clr),
        .i_add_en  (w_legal),
        .i_add_val (prod_commit_len),
        .o_acc     (w_acc_q),
        .o_sum_c   (w_acc_sum)
    );

    uvc_sat_acc #(
        .W     (OVR_CNT_W),
        .ADD_W (1)
    ) u_ovr_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (1'b0),
        .i_add_en  (w_illegal),
        .i_add_val (1'b1),
        .o_acc     (w_ovr_q),
        .o_sum_c   (w_ovr_sum_unused)
    );

    // Next-state, budget and SI latch decode.
    always_comb begin
        w_state_d = r_state;
        w_pkts_d  = w_legal ? (r_pkts_left - PKT_CNT_W'(1)) : r_pkts_left;
        w_acc_clr = 1'b0;
        w_bytes_d = r_bytes_sent;
        w_valid_d = 1'b0;
        w_open_d  = r_open;
        w_grant_d = 1'b0;

        if (prod_commit)
            w_open_d = 1'b0;
        else if (prod_wren)
            w_open_d = 1'b1;

        case (r_state)
            ST_DISABLED: begin
                if (intf_set)
                    w_state_d = ST_WAIT_ITP;
            end
            ST_WAIT_ITP: begin
                if (!intf_set) begin
                    w_state_d = w_open_d ? ST_DRAIN : ST_DISABLED;
                end else if (itp_recieved) begin
                    w_state_d = ST_ACTIVE;
                    w_pkts_d  = w_budget;
                    w_acc_clr = 1'b1;
                end
            end
            ST_ACTIVE, ST_EXHAUSTED: begin
                if (!intf_set) begin
                    w_state_d = w_open_d ? ST_DRAIN : ST_DISABLED;
                end else if (itp_recieved) begin
                    // A coincident legal commit lands in the SI being closed.
                    w_bytes_d = w_acc_sum;
                    w_valid_d = 1'b1;
                    w_state_d = ST_ACTIVE;
                    w_pkts_d  = w_budget;
                    w_acc_clr = 1'b1;
                end else if (w_pkts_d == '0) begin
                    w_state_d = ST_EXHAUSTED;
                end
            end
            ST_DRAIN: begin
                if (prod_commit)
                    w_state_d = ST_DISABLED;
            end
            default: begin
                w_state_d = ST_DISABLED;
            end
        endcase

        if (w_state_d == ST_DISABLED) begin
            w_pkts_d  = '0;
            w_acc_clr = 1'b1;
        end

        w_grant_d = (w_state_d == ST_ACTIVE) && (w_pkts_d != '0) && !w_open_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_DISABLED;
            r_open       <= 1'b0;
            r_grant      <= 1'b0;
            r_active     <= 1'b0;
            r_valid      <= 1'b0;
            r_pkts_left  <= '0;
            r_bytes_sent <= '0;
        end else begin
            r_state      <= w_state_d;
            r_open       <= w_open_d;
            r_grant      <= w_grant_d;
            r_active     <= (w_state_d == ST_ACTIVE) || (w_state_d == ST_EXHAUSTED);
            r_valid      <= w_valid_d;
            r_pkts_left  <= w_pkts_d;
            r_bytes_sent <= w_bytes_d;
        end
    end

    assign sched_in_buf_ready = ep_in_buf_ready && r_grant;
    assign sched_active       = r_active;
    assign pkts_left          = r_pkts_left;
    assign si_bytes_sent      = r_bytes_sent;
    assign si_bytes_valid     = r_valid;
    assign overrun_cnt        = w_ovr_q;

endmodule
